al_clk_controller: RTL

Keypad-driven sequencer for the alarm clock, running in the clk256 domain beside al_clk_counter.
- Decodes key presses into a BCD HHMM entry buffer and validates it.
- Issues load_new_time / load_new_alarm strobes and selects the display mode.
- Derives the one_minute tick for the time counter from a one_second pulse, resynchronising the seconds count whenever a new time is loaded.

---
 rtl/al_clk_controller_if.sv | 25 ++
 rtl/al_clk_controller.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/al_clk_controller_if.sv
// rtl/al_clk_controller_if.sv - keypad/strobe bundle between alarm clock controller and its neighbours
interface al_clk_controller_if;
  logic        one_second;
  logic        key_valid;
  logic [3:0]  key;
  logic [15:0] new_time;
  logic        load_new_time;
  logic        load_new_alarm;
  logic        one_minute;
  logic        show_new_time;
  logic        show_alarm;
  logic        entry_error;

  modport master (
    output one_second, key_valid, key,
    input  new_time, load_new_time, load_new_alarm, one_minute,
           show_new_time, show_alarm, entry_error
  );

  modport slave (
    input  one_second, key_valid, key,
    output new_time, load_new_time, load_new_alarm, one_minute,
           show_new_time, show_alarm, entry_error
  );
endinterface

// File: rtl/al_clk_controller.sv
// rtl/al_clk_controller.sv - keypad sequencer: BCD HHMM entry, load strobes, display select, minute tick
module al_clk_controller #(
  parameter int TIMEOUT_SEC    = 10,
  parameter int SHOW_ALARM_SEC = 5,
  parameter int SEC_PER_MIN    = 60
) (
  input  logic              clk256,
  input  logic              reset,
  al_clk_controller_if.slave bus
);
  localparam int TO_W = $clog2(TIMEOUT_SEC + 1);
  localparam int SA_W = $clog2(SHOW_ALARM_SEC + 1);
  localparam int SC_W = $clog2(SEC_PER_MIN + 1);

  localparam logic [3:0] KEY_ALARM = 4'hA;
  localparam logic [3:0] KEY_TIME  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  typedef enum logic [1:0] {IDLE, ENTRY, SHOW_AL} state_t;

  state_t          state_q;
  logic [15:0]     new_time_q;
  logic            load_time_q;
  logic            load_alarm_q;
  logic            one_minute_q;
  logic            show_new_time_q;
  logic            show_alarm_q;
  logic            entry_error_q;
  logic [SC_W-1:0] sec_cnt_q;
  logic [TO_W-1:0] timeout_cnt_q;
  logic [SA_W-1:0] show_cnt_q;

  logic key_ok;
  logic key_digit;
  logic entry_valid;
  logic load_time_d;

  // Every buffered nibble came from a 0-9 key, so H0<=9 and M0 need no check.
  always_comb begin
    key_ok      = bus.key_valid && (bus.key <= KEY_CLEAR);
    key_digit   = key_ok && (bus.key <= 4'h9);
    entry_valid = (new_time_q[15:12] <= 4'h2) &&
                  ((new_time_q[15:12] != 4'h2) || (new_time_q[11:8] <= 4'h3)) &&
                  (new_time_q[7:4] <= 4'h5);
    load_time_d = (state_q == ENTRY) && key_ok && (bus.key == KEY_TIME) && entry_valid;
  end

  always_ff @(posedge clk256 or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      new_time_q      <= 16'h0000;
      load_time_q     <= 1'b0;
      load_alarm_q    <= 1'b0;
      one_minute_q    <= 1'b0;
      show_new_time_q <= 1'b0;
      show_alarm_q    <= 1'b0;
      entry_error_q   <= 1'b0;
      sec_cnt_q       <= '0;
      timeout_cnt_q   <= '0;
      show_cnt_q      <= '0;
    end else begin
      load_time_q   <= load_time_d;
      load_alarm_q  <= 1'b0;
      entry_error_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (key_digit) begin
            state_q         <= ENTRY;
            new_time_q      <= {12'h000, bus.key};
            timeout_cnt_q   <= '0;
            show_new_time_q <= 1'b1;
          end else if (key_ok && (bus.key == KEY_ALARM)) begin
            state_q      <= SHOW_AL;
            show_cnt_q   <= '0;
            show_alarm_q <= 1'b1;
          end
        end

        ENTRY: begin
          if (key_ok) begin
            timeout_cnt_q <= '0;
            if (key_digit) begin
              new_time_q <= {new_time_q[11:0], bus.key};
            end else if (bus.key == KEY_CLEAR) begin
              new_time_q <= 16'h0000;
            end else begin
              state_q         <= IDLE;
              show_new_time_q <= 1'b0;
              if (!entry_valid) begin
                entry_error_q <= 1'b1;
              end else if (bus.key == KEY_ALARM) begin
                load_alarm_q <= 1'b1;
              end
            end
          end else if (bus.one_second) begin
            if (timeout_cnt_q == TO_W'(TIMEOUT_SEC - 1)) begin
              state_q         <= IDLE;
              show_new_time_q <= 1'b0;
              new_time_q      <= 16'h0000;
              timeout_cnt_q   <= '0;
            end else begin
              timeout_cnt_q <= timeout_cnt_q + 1'b1;
            end
          end
        end

        SHOW_AL: begin
          if (key_ok || (bus.one_second && (show_cnt_q == SA_W'(SHOW_ALARM_SEC - 1)))) begin
            state_q      <= IDLE;
            show_alarm_q <= 1'b0;
          end else if (bus.one_second) begin
            show_cnt_q <= show_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q         <= IDLE;
          show_new_time_q <= 1'b0;
          show_alarm_q    <= 1'b0;
        end
      endcase

      // Loading a new time restarts the minute so the first tick is a full minute later.
      if (load_time_d) begin
        sec_cnt_q    <= '0;
        one_minute_q <= 1'b0;
      end else if (bus.one_second) begin
        if (sec_cnt_q == SC_W'(SEC_PER_MIN - 1)) begin
          sec_cnt_q    <= '0;
          one_minute_q <= 1'b1;
        end else begin
          sec_cnt_q    <= sec_cnt_q + 1'b1;
          one_minute_q <= 1'b0;
        end
      end else begin
        one_minute_q <= 1'b0;
      end
    end
  end

  assign bus.new_time       = new_time_q;
  assign bus.load_new_time  = load_time_q;
  assign bus.load_new_alarm = load_alarm_q;
  assign bus.one_minute     = one_minute_q;
  assign bus.show_new_time  = show_new_time_q;
  assign bus.show_alarm     = show_alarm_q;
  assign bus.entry_error    = entry_error_q;
endmodule
